// File: rtl/button_bcd_counter.sv
// Push-button press counter with a two-digit BCD display value (00-99).
// The raw switch is synchronized, debounced, and edge-detected. Each
// debounced press advances the ones/tens digits, which roll over 99 -> 00.
// Every output comes straight from a register.
module button_bcd_counter #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch,
    input  logic       i_Clear,
    output logic       o_Button,
    output logic       o_Press,
    output logic       o_Wrap,
    output logic [3:0] o_Ones,
    output logic [3:0] o_Tens
);

    localparam int CW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          button_q, button_d;
    logic          button_prev_q;
    logic          press_q, press_d;
    logic          wrap_q, wrap_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic          press_evt;

    // Press event: debounced level is high now but was low one clock ago.
    assign press_evt = button_q & ~button_prev_q;

    // Debouncer: the level flips only after the synchronized input has
    // differed from it for DEBOUNCE_LIMIT consecutive clocks. Any bounce
    // back to the current level restarts the run from zero.
    always_comb begin
        cnt_d    = cnt_q;
        button_d = button_q;
        if (sync2_q == button_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            button_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // BCD counter: a clear wins over a coincident press, and that press is
    // dropped rather than held. Wrap pulses together with the press that
    // rolls 99 -> 00.
    always_comb begin
        ones_d  = ones_q;
        tens_d  = tens_q;
        press_d = 1'b0;
        wrap_d  = 1'b0;
        if (i_Clear) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (press_evt) begin
            press_d = 1'b1;
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                if (tens_q == 4'd9) begin
                    tens_d = 4'd0;
                    wrap_d = 1'b1;
                end else begin
                    tens_d = tens_q + 4'd1;
                end
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // State registers; reset clears everything, including the edge-detect
    // history, so a button held through reset is counted only after it is
    // debounced again.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            cnt_q         <= '0;
            button_q      <= 1'b0;
            button_prev_q <= 1'b0;
            press_q       <= 1'b0;
            wrap_q        <= 1'b0;
            ones_q        <= 4'd0;
            tens_q        <= 4'd0;
        end else begin
            sync1_q       <= i_Switch;
            sync2_q       <= sync1_q;
            cnt_q         <= cnt_d;
            button_q      <= button_d;
            button_prev_q <= button_q;
            press_q       <= press_d;
            wrap_q        <= wrap_d;
            ones_q        <= ones_d;
            tens_q        <= tens_d;
        end
    end

    assign o_Button = button_q;
    assign o_Press  = press_q;
    assign o_Wrap   = wrap_q;
    assign o_Ones   = ones_q;
    assign o_Tens   = tens_q;

endmodule
